// File: rtl/cpstr_unesc.sv
// Control-protocol unescaper: splits an escaped byte stream into data and OOB streams, 1-cycle latency.
// Input ready is gated only by the output register the current byte targets.
module cpstr_unesc #(
   parameter logic [7:0] ESC_CHAR = 8'd27
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [7:0] o_oob_data,
   output logic       o_oob_valid,
   input  logic       i_oob_ready,
   output logic       o_esc_pending
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ESC = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_is_esc;
   logic       w_accept;
   logic       w_tgt_data;
   logic       w_tgt_oob;
   logic [7:0] r_data;
   logic       r_valid;
   logic [7:0] r_oob_data;
   logic       r_oob_valid;

   assign w_is_esc = (i_data == ESC_CHAR);
   assign w_accept = i_valid && o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         if (r_state == ST_IDLE) begin
            if (w_is_esc) begin
               w_state_nxt = ST_ESC;
            end
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // ESC in IDLE targets nothing and is always accepted.
   always_comb begin
      w_tgt_data    = 1'b0;
      w_tgt_oob     = 1'b0;
      o_esc_pending = 1'b0;
      o_ready       = 1'b1;
      if (r_state == ST_IDLE) begin
         w_tgt_data = !w_is_esc;
      end else begin
         o_esc_pending = 1'b1;
         w_tgt_data    = w_is_esc;
         w_tgt_oob     = !w_is_esc;
      end
      if (w_tgt_data) begin
         o_ready = !r_valid || i_ready;
      end else if (w_tgt_oob) begin
         o_ready = !r_oob_valid || i_oob_ready;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= 8'd0;
         r_valid <= 1'b0;
      end else if (w_accept && w_tgt_data) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_oob_data  <= 8'd0;
         r_oob_valid <= 1'b0;
      end else if (w_accept && w_tgt_oob) begin
         r_oob_data  <= i_data;
         r_oob_valid <= 1'b1;
      end else if (i_oob_ready) begin
         r_oob_valid <= 1'b0;
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_oob_data  = r_oob_data;
   assign o_oob_valid = r_oob_valid;

endmodule

// File: doc/cpstr_unesc.md
# cpstr_unesc

Stream unescaper for the control-protocol byte stream: consumes the escaped byte stream produced by the matching escaper on the far side of the link and splits it back into a plain data stream and an out-of-band (OOB) byte stream. It sits directly downstream of the link receive path and feeds the control-protocol parser (data) and the command/marker handler (OOB). Each output has a one-entry registered stage with full-throughput valid/ready handshaking.

## Interface

Parameters:

- `ESC_CHAR`, default `8'd27` — escape byte value.

Ports:

- `i_clk` in 1 — clock; all logic on rising edge.
- `i_rst_n` in 1 — reset, asynchronous, active-low.
- `i_data` in 8 — escaped input byte.
- `i_valid` in 1 — input byte valid.
- `o_ready` out 1 — input byte accepted when `i_valid && o_ready`.
- `o_data` out 8 — unescaped data byte.
- `o_valid` out 1 — data byte valid.
- `i_ready` in 1 — data sink ready.
- `o_oob_data` out 8 — out-of-band byte.
- `o_oob_valid` out 1 — OOB byte valid.
- `i_oob_ready` in 1 — OOB sink ready.
- `o_esc_pending` out 1 — high while in state ESC (an escape has been received and its second byte has not yet been accepted).

## Operation

Protocol (fixed):

- Plain byte B != ESC_CHAR → data B.
- ESC_CHAR ESC_CHAR → data ESC_CHAR.
- ESC_CHAR X, with X != ESC_CHAR → OOB byte X.

State machine with 2 states, IDLE and ESC. Reset state is IDLE. On each accepted input byte:

- IDLE, byte == ESC_CHAR → go to ESC; no output produced.
- IDLE, byte != ESC_CHAR → load data register with the byte; stay in IDLE.
- ESC, byte == ESC_CHAR → load data register with ESC_CHAR; go to IDLE.
- ESC, byte != ESC_CHAR → load OOB register with the byte; go to IDLE.

Target selection is combinational on `state` and `i_data`.

`o_ready`:

- 1 when the target is "none" (IDLE with ESC_CHAR on input).
- Target data: `!o_valid || i_ready`.
- Target OOB: `!o_oob_valid || i_oob_ready`.

Output registers:

- Each register holds its byte until its handshake completes.
- A simultaneous drain and load of the same register in one cycle keeps valid high with the new byte.
- `o_ready` may depend on `i_valid` and `i_data`. Output valids never depend on the sink readies.

Ordering:

- Order is preserved within each output stream.
- Order across the two streams is not enforced. An OOB byte may become valid while an earlier data byte is still held in the data register; consumers needing cross-stream ordering must drain data first.

## Timing

- Reset values: `o_valid = 0`, `o_oob_valid = 0`, `o_data = 0`, `o_oob_data = 0`, `o_esc_pending = 0`, state = IDLE.
- Asynchronous assertion of reset clears everything immediately, including a pending escape and held output bytes. These are lost and not replayed.
- Latency: 1 cycle from input accept to the output valid rising edge.
- ESC_CHAR in IDLE produces no output and costs 1 cycle.
- Throughput: 1 input byte/cycle while the target register drains every cycle.
  - Plain stream: 1 output/cycle.
  - Escaped pairs: 1 output per 2 cycles.
- Backpressure is per target:
  - A stalled OOB sink blocks input only when the next byte targets OOB.
  - A plain byte arriving while the OOB register is full and the data register is free is accepted.
- State ESC persists indefinitely across input idle cycles (`i_valid = 0`).
- A stall on the second byte of a pair holds ESC and `o_esc_pending` high.
- No consecutive-ESC limit exists. ESC ESC ESC is decoded as data ESC_CHAR, followed by state ESC.

## Test plan

- Pass-through, sinks ready: input 0x01 0x02 0x03 → `o_data` 0x01, 0x02, 0x03 on 3 consecutive cycles, each 1 cycle after its accept; `o_oob_valid` stays 0.
- Escaped data: input 0x1B 0x1B 0x05 → data 0x1B then 0x05; `o_esc_pending` high for exactly 1 cycle; 3 inputs accepted in 3 cycles.
- OOB: input 0x04 0x1B 0xBE 0x06 → data 0x04 and 0x06; OOB 0xBE valid 1 cycle after 0xBE is accepted; `o_valid` stays low on the 0xBE cycle.
- Backpressure:
  - Part 1: `i_ready = 0` for 3 cycles during 0x01 0x02 → `o_data` holds 0x01 with `o_ready = 0`, 0x02 is not lost, and 0x02 follows 1 cycle after release.
  - Part 2: `i_oob_ready = 0` with OOB 0xBE held → a following plain 0x07 is still accepted and output; a second escape pair 0x1B 0xCA stalls on 0xCA with `o_esc_pending = 1` until the OOB register drains.
- Reset mid-escape: input 0x1B, then `i_rst_n` pulsed low mid-cycle → outputs go to 0 asynchronously and `o_esc_pending = 0`; subsequent 0x1B 0x1B after reset yields data 0x1B (no stale state).
- Stream-generator soak: data counter d = 0..255, sending d+1 when d[2:0] < 5 and 0x1B otherwise, escaped by the escaper with random OOB inserts and random sink stalls → data output matches the pre-escape sequence exactly and OOB output matches the inserted bytes in order.
